// File: rtl/elastic_pipe_chain.sv
// elastic_pipe_chain
//   Back-pressured register chain for cutting long timing paths between core
//   units (fetch -> istream, decode -> fetch branch update, ...). DEPTH skid
//   stages sit in series. Each stage holds two entries, so the chain keeps one
//   transfer per cycle, and every ready is a flop output.
//
//   Ports
//     CLK        clock
//     nRST       synchronous active-low reset: clears every count and loads
//                RESET_DATA into every data register
//     flush      squash all buffered entries. A same-cycle enq is dropped.
//                A same-cycle deq still counts as taken.
//     enq_valid  producer has a transfer
//     enq_data   producer payload
//     enq_ready  chain accepts a transfer this cycle (registered, stage 0)
//     deq_valid  head entry valid
//     deq_data   head entry payload (holds last head when deq_valid=0)
//     deq_ready  consumer takes head this cycle
//     occupancy  total valid entries across all stages, 0..2*DEPTH

// One skid stage: a main register feeding the output, plus a skid register
// that catches the one transfer already in flight when out_ready drops.
module elastic_pipe_stage #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] main_q, skid_q;
  logic [1:0]       cnt_q;
  logic             push, pop;

  // Ready depends on stored state only, so deq_ready never reaches enq_ready
  // through logic.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = main_q;
  assign cnt       = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q  <= 2'd0;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else if (flush) begin
      // Only the counts clear. Stale data stays but is never presented
      // as valid.
      cnt_q <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            main_q <= in_data;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              skid_q <= in_data;
              cnt_q  <= 2'd2;
            end
            2'b11: main_q <= in_data;
            2'b01: cnt_q  <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          // in_ready is low here, so the only legal move is a pop. The skid
          // entry then becomes the head.
          if (pop) begin
            main_q <= skid_q;
            cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end
endmodule

module elastic_pipe_chain #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             flush,
  input  logic                             enq_valid,
  input  logic [WIDTH-1:0]                 enq_data,
  output logic                             enq_ready,
  output logic                             deq_valid,
  output logic [WIDTH-1:0]                 deq_data,
  input  logic                             deq_ready,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);
  localparam int OCC_W = $clog2(2*DEPTH+1);

  if (DEPTH < 1) begin : g_depth_chk
    $error("elastic_pipe_chain: DEPTH must be >= 1");
  end

  // Link g connects stage g-1 to stage g. Link 0 is the enq side and
  // link DEPTH is the deq side.
  logic [DEPTH:0]            link_valid, link_ready;
  logic [DEPTH:0][WIDTH-1:0] link_data;
  logic [DEPTH-1:0][1:0]     stage_cnt;
  logic [OCC_W-1:0]          occ_sum;

  assign link_valid[0]     = enq_valid;
  assign link_data[0]      = enq_data;
  assign enq_ready         = link_ready[0];
  assign deq_valid         = link_valid[DEPTH];
  assign deq_data          = link_data[DEPTH];
  assign link_ready[DEPTH] = deq_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    elastic_pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .CLK       (CLK),
      .nRST      (nRST),
      .flush     (flush),
      .in_valid  (link_valid[g]),
      .in_data   (link_data[g]),
      .in_ready  (link_ready[g]),
      .out_valid (link_valid[g+1]),
      .out_data  (link_data[g+1]),
      .out_ready (link_ready[g+1]),
      .cnt       (stage_cnt[g])
    );
  end

  // Sum of registered counts. The maximum is 2*DEPTH, which OCC_W always
  // holds, so the sum cannot wrap.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_sum = occ_sum + OCC_W'(stage_cnt[i]);
  end

  assign occupancy = occ_sum;
endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Three chains run side by side: k=0 DEPTH=2/W32, k=1 DEPTH=1/W32,
// k=2 DEPTH=3/W8. Accepted enqs go into a per-chain expected queue. A
// monitor pops and compares on every deq handshake. It also compares
// occupancy with accepted - delivered on every cycle.
module tb_elastic_pipe_chain;
  logic CLK;
  logic [2:0]        nrst, fl, ev, dr, er, dv;
  logic [2:0][31:0]  ed, dd;
  logic [2:0][2:0]   oc;
  logic [1:0]        oc1;
  logic [7:0]        dd2;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$], q1[$], q2[$];
  int occm[3];
  bit en[3];

  localparam logic [31:0] RST0 = 32'hDEAD_BEEF;

  elastic_pipe_chain #(.WIDTH(32), .DEPTH(2), .RESET_DATA(RST0)) u_d2 (
    .CLK(CLK), .nRST(nrst[0]), .flush(fl[0]), .enq_valid(ev[0]), .enq_data(ed[0]),
    .enq_ready(er[0]), .deq_valid(dv[0]), .deq_data(dd[0]), .deq_ready(dr[0]),
    .occupancy(oc[0]));

  elastic_pipe_chain #(.WIDTH(32), .DEPTH(1), .RESET_DATA(32'h0)) u_d1 (
    .CLK(CLK), .nRST(nrst[1]), .flush(fl[1]), .enq_valid(ev[1]), .enq_data(ed[1]),
    .enq_ready(er[1]), .deq_valid(dv[1]), .deq_data(dd[1]), .deq_ready(dr[1]),
    .occupancy(oc1));
  assign oc[1] = {1'b0, oc1};

  elastic_pipe_chain #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'h0)) u_d3 (
    .CLK(CLK), .nRST(nrst[2]), .flush(fl[2]), .enq_valid(ev[2]), .enq_data(ed[2][7:0]),
    .enq_ready(er[2]), .deq_valid(dv[2]), .deq_data(dd2), .deq_ready(dr[2]),
    .occupancy(oc[2]));
  assign dd[2] = {24'h0, dd2};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic void q_push(int k, logic [31:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  function automatic logic [31:0] q_pop(int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_clear(int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Runs at every negedge. At that point the inputs are stable and the
  // handshakes seen will be taken at the next posedge.
  task automatic monitor();
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        int del;
        int acc;
        logic [31:0] m;
        del = 0;
        acc = 0;
        m = (k == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        if (en[k]) chk($sformatf("occ_k%0d", k), 32'(oc[k]), 32'(occm[k]));
        if (nrst[k] && dv[k] && dr[k]) begin
          del = 1;
          if (q_size(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_extra_k%0d actual=%h expected=none t=%0t", k, dd[k], $time);
          end else begin
            chk($sformatf("deq_data_k%0d", k), dd[k], q_pop(k));
          end
        end
        if (nrst[k] && !fl[k] && ev[k] && er[k]) acc = 1;
        if (!nrst[k] || fl[k]) begin
          q_clear(k);
          occm[k] = 0;
        end else begin
          if (acc == 1) q_push(k, ed[k] & m);
          occm[k] = occm[k] + acc - del;
        end
        if (!nrst[k]) en[k] = 1'b1;
      end
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    int n;
    nrst = '0; fl = '0; ev = '0; dr = '0; ed = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge CLK);
    #1;
    nrst = '1;
    smp();
    chk("rst_dv", dv[0], 1'b0);
    chk("rst_er", er[0], 1'b1);
    chk("rst_occ", 32'(oc[0]), 32'd0);
    chk("rst_dd", dd[0], RST0);
    chk("rst_er_d1", er[1], 1'b1);
    chk("rst_dv_d3", dv[2], 1'b0);

    // Latency/throughput on DEPTH=2. A0 shows up two cycles after its enq.
    for (int i = 0; i < 5; i++) begin
      nxt();
      dr[0] = 1'b1;
      ev[0] = (i < 3);
      ed[0] = 32'h0000_00A0 + 32'(i);
      smp();
      chk($sformatf("t1_dv_c%0d", i), dv[0], (i >= 2));
      if (i >= 2) chk($sformatf("t1_dd_c%0d", i), dd[0], 32'h0000_00A0 + 32'(i - 2));
      chk($sformatf("t1_occ_le2_c%0d", i), (oc[0] <= 3'd2), 1'b1);
    end
    nxt(); ev[0] = 1'b0;
    repeat (2) nxt();

    // Backpressure. With deq blocked, exactly 4 enqs are accepted, then ready drops.
    n = 1;
    for (int c = 0; c < 8; c++) begin
      nxt();
      dr[0] = 1'b0;
      ev[0] = 1'b1;
      ed[0] = 32'(n);
      smp();
      chk($sformatf("t2_er_c%0d", c), er[0], (c < 4));
      if (er[0]) n++;
    end
    chk("t2_accepted", 32'(n - 1), 32'd4);
    chk("t2_occ_full", 32'(oc[0]), 32'd4);
    for (int j = 0; j < 5; j++) begin
      nxt();
      ev[0] = 1'b0;
      dr[0] = 1'b1;
      smp();
      chk($sformatf("t2_dv_j%0d", j), dv[0], (j < 4));
      if (j < 4) chk($sformatf("t2_dd_j%0d", j), dd[0], 32'(j + 1));
      if (j == 0) chk("t2_er_j0", er[0], 1'b0);
      if (j == 2) chk("t2_er_j2", er[0], 1'b1);
    end

    // Flush with 3 entries. The head is delivered, 0x55 is dropped, all else is squashed.
    for (int c = 0; c < 4; c++) begin
      nxt();
      dr[0] = 1'b0;
      ev[0] = (c < 3);
      ed[0] = 32'h10 + 32'(c);
    end
    smp();
    chk("t3_occ3", 32'(oc[0]), 32'd3);
    nxt();
    fl[0] = 1'b1; ev[0] = 1'b1; ed[0] = 32'h55; dr[0] = 1'b1;
    smp();
    chk("t3_head_dv", dv[0], 1'b1);
    chk("t3_head_dd", dd[0], 32'h10);
    nxt();
    fl[0] = 1'b0; ev[0] = 1'b0;
    smp();
    chk("t3_occ0", 32'(oc[0]), 32'd0);
    chk("t3_dv0", dv[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      nxt();
      smp();
      chk($sformatf("t3_no55_c%0d", c), dv[0], 1'b0);
    end

    // Reset mid-stream with 3 entries held. 0x77 then has the plain 2-cycle latency.
    for (int c = 0; c < 4; c++) begin
      nxt();
      dr[0] = 1'b0;
      ev[0] = (c < 3);
      ed[0] = 32'h20 + 32'(c);
    end
    smp();
    chk("t4_occ3", 32'(oc[0]), 32'd3);
    nxt();
    nrst[0] = 1'b0;
    nxt();
    nrst[0] = 1'b1; ev[0] = 1'b1; ed[0] = 32'h77; dr[0] = 1'b1;
    smp();
    chk("t4_occ0", 32'(oc[0]), 32'd0);
    chk("t4_dv0", dv[0], 1'b0);
    chk("t4_er1", er[0], 1'b1);
    chk("t4_dd_rst", dd[0], RST0);
    nxt();
    ev[0] = 1'b0;
    smp();
    chk("t4_dv_wait", dv[0], 1'b0);
    nxt();
    smp();
    chk("t4_dv77", dv[0], 1'b1);
    chk("t4_dd77", dd[0], 32'h77);

    // DEPTH=1 single skid. enq held high, deq_ready toggles 1010...
    n = 100;
    for (int c = 0; c < 12; c++) begin
      nxt();
      ev[1] = 1'b1;
      ed[1] = 32'(n);
      dr[1] = (c % 2 == 0);
      smp();
      chk($sformatf("t5_er_c%0d", c), er[1], (c < 2) || (c % 2 == 1));
      chk($sformatf("t5_dv_c%0d", c), dv[1], (c >= 1));
      if (er[1]) n++;
    end
    nxt();
    ev[1] = 1'b0; dr[1] = 1'b1;
    repeat (4) nxt();

    // Random traffic on DEPTH=3, 8-bit payload.
    for (int c = 0; c < 10000; c++) begin
      nxt();
      ev[2] = 1'($urandom_range(0, 1));
      dr[2] = 1'($urandom_range(0, 1));
      ed[2] = 32'($urandom_range(0, 255));
    end
    nxt();
    ev[2] = 1'b0; dr[2] = 1'b1;
    repeat (10) nxt();

    smp();
    chk("end_q0_empty", 32'(q_size(0)), 32'd0);
    chk("end_q1_empty", 32'(q_size(1)), 32'd0);
    chk("end_q2_empty", 32'(q_size(2)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
